// File: rtl/udsp_frame_sequencer.sv
// Per-sample frame controller: loads inputs, releases the core for one pass, streams results out.
// Optional saturating overrun counter enabled by defining UDSP_SEQ_OVERRUN_CNT_EN.
module udsp_frame_sequencer #(
   parameter int unsigned DAW        = 10,
   parameter int unsigned DWW        = 36,
   parameter int unsigned PROG_LEN   = 512,
   parameter int unsigned PIPE_DRAIN = 3,
   parameter int unsigned N_IN       = 8,
   parameter int unsigned N_OUT      = 8,
   parameter int unsigned IN_BASE    = 0,
   parameter int unsigned OUT_BASE   = 64
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           sample_tick,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [DWW-1:0] in_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [DWW-1:0] out_data,
   output logic           core_start,
   input  logic [DAW-1:0] core_addrW,
   input  logic [DWW-1:0] core_dataW,
   input  logic           core_we,
   input  logic [DAW-1:0] core_addrB,
   output logic [DAW-1:0] mem_addrW,
   output logic [DWW-1:0] mem_dataW,
   output logic           mem_we,
   output logic [DAW-1:0] mem_addrB,
   input  logic [DWW-1:0] mem_dataB,
   output logic           busy,
   output logic [7:0]     overrun_cnt
);

   localparam int unsigned RunLen = PROG_LEN + PIPE_DRAIN;
   localparam int unsigned RunW   = $clog2(RunLen + 1);
   localparam logic [DAW-1:0] InBaseA  = DAW'(IN_BASE);
   localparam logic [DAW-1:0] OutBaseA = DAW'(OUT_BASE);

   typedef enum logic [2:0] {StIdle, StLoad, StRun, StRd, StCap, StHold} state_e;

   state_e          state_q, state_d;
   logic [6:0]      in_idx_q, in_idx_d;
   logic [6:0]      out_idx_q, out_idx_d;
   logic [RunW-1:0] run_q, run_d;
   logic [DWW-1:0]  out_data_q, out_data_d;
   logic            out_valid_q, out_valid_d;
   logic [DAW-1:0]  in_addr, out_addr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         in_idx_q    <= '0;
         out_idx_q   <= '0;
         run_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_idx_q    <= in_idx_d;
         out_idx_q   <= out_idx_d;
         run_q       <= run_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      in_idx_d    = in_idx_q;
      out_idx_d   = out_idx_q;
      run_d       = run_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         StIdle: begin
            if (sample_tick) begin
               state_d  = StLoad;
               in_idx_d = '0;
            end
         end
         StLoad: begin
            if (in_valid) begin
               if (in_idx_q == 7'(N_IN - 1)) begin
                  state_d = StRun;
                  run_d   = '0;
               end else begin
                  in_idx_d = in_idx_q + 7'd1;
               end
            end
         end
         StRun: begin
            if (run_q == RunW'(RunLen - 1)) begin
               state_d   = StRd;
               out_idx_d = '0;
            end else begin
               run_d = run_q + RunW'(1);
            end
         end
         StRd: state_d = StCap;
         StCap: begin
            // Port-B data for the address issued in StRd arrives this cycle.
            out_data_d  = mem_dataB;
            out_valid_d = 1'b1;
            state_d     = StHold;
         end
         StHold: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (out_idx_q == 7'(N_OUT - 1)) begin
                  state_d = StIdle;
               end else begin
                  out_idx_d = out_idx_q + 7'd1;
                  state_d   = StRd;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign in_addr  = InBaseA + DAW'(in_idx_q);
   assign out_addr = OutBaseA + DAW'(out_idx_q);

   always_comb begin
      in_ready   = (state_q == StLoad);
      core_start = (state_q != StRun);
      busy       = (state_q != StIdle);
      out_valid  = out_valid_q;
      out_data   = out_data_q;
      if (state_q == StRun) begin
         mem_we    = core_we;
         mem_addrW = core_addrW;
         mem_dataW = core_dataW;
         mem_addrB = core_addrB;
      end else begin
         mem_we    = (state_q == StLoad) && in_valid;
         mem_addrW = in_addr;
         mem_dataW = in_data;
         mem_addrB = out_addr;
      end
   end

`ifdef UDSP_SEQ_OVERRUN_CNT_EN
   logic [7:0] overrun_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         overrun_q <= '0;
      end else if (sample_tick && (state_q != StIdle) && (overrun_q != 8'hFF)) begin
         overrun_q <= overrun_q + 8'd1;
      end
   end

   assign overrun_cnt = overrun_q;
`else
   assign overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_udsp_frame_sequencer.sv
// Directed bench for udsp_frame_sequencer with a small port-B memory model.
module tb_udsp_frame_sequencer;

   localparam int unsigned DAW = 10;
   localparam int unsigned DWW = 36;
`ifdef UDSP_SEQ_OVERRUN_CNT_EN
   localparam bit OvrEn = 1'b1;
`else
   localparam bit OvrEn = 1'b0;
`endif

   logic           clk;
   logic           reset;
   logic           sample_tick;
   logic           in_valid;
   logic           in_ready;
   logic [DWW-1:0] in_data;
   logic           out_valid;
   logic           out_ready;
   logic [DWW-1:0] out_data;
   logic           core_start;
   logic [DAW-1:0] core_addrW;
   logic [DWW-1:0] core_dataW;
   logic           core_we;
   logic [DAW-1:0] core_addrB;
   logic [DAW-1:0] mem_addrW;
   logic [DWW-1:0] mem_dataW;
   logic           mem_we;
   logic [DAW-1:0] mem_addrB;
   logic [DWW-1:0] mem_dataB;
   logic           busy;
   logic [7:0]     overrun_cnt;

   logic           preload;
   logic [DWW-1:0] mem [0:1023];

   int checks   = 0;
   int failures = 0;
   int exp_ovr  = 0;
   int n;

   udsp_frame_sequencer #(
      .DAW(DAW), .DWW(DWW), .PROG_LEN(16), .PIPE_DRAIN(3),
      .N_IN(2), .N_OUT(2), .IN_BASE(0), .OUT_BASE(8)
   ) dut (
      .clk(clk), .reset(reset), .sample_tick(sample_tick),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .core_start(core_start), .core_addrW(core_addrW), .core_dataW(core_dataW),
      .core_we(core_we), .core_addrB(core_addrB),
      .mem_addrW(mem_addrW), .mem_dataW(mem_dataW), .mem_we(mem_we),
      .mem_addrB(mem_addrB), .mem_dataB(mem_dataB),
      .busy(busy), .overrun_cnt(overrun_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (preload) begin
         mem[8] <= 36'hA5;
         mem[9] <= 36'h5A;
      end else if (mem_we) begin
         mem[mem_addrW] <= mem_dataW;
      end
      mem_dataB <= mem[mem_addrB];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int ovr(input int v);
      return OvrEn ? ((v > 255) ? 255 : v) : 0;
   endfunction

   // Tick, then load two samples; returns in the first RUN cycle.
   task automatic load2(input logic [DWW-1:0] a, input logic [DWW-1:0] b);
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      check("load_in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = a;
      #1;
      check("ld0_we", mem_we, 1);
      check("ld0_addr", mem_addrW, 0);
      check("ld0_data", mem_dataW, a);
      step();
      in_data = b;
      #1;
      check("ld1_addr", mem_addrW, 1);
      check("ld1_data", mem_dataW, b);
      step();
      in_valid = 1'b0;
   endtask

   task automatic run_count(output int cnt);
      cnt = 0;
      while (core_start === 1'b0 && cnt < 100) begin
         cnt++;
         step();
      end
   endtask

   task automatic wait_out(input string tag, input logic [DWW-1:0] exp);
      for (int k = 0; k < 20 && out_valid !== 1'b1; k++) step();
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_data"}, out_data, exp);
   endtask

   initial begin
      reset = 1'b1; sample_tick = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      core_we = 1'b0; core_addrW = '0; core_dataW = '0; core_addrB = '0; preload = 1'b1;
      step();
      step();
      preload = 1'b0;
      check("rst_core_start", core_start, 1);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun_cnt, 0);
      reset = 1'b0;
      step();

      // Frame 1: basic with backpressure on the first output
      load2(36'h11, 36'h22);
      check("run_in_ready", in_ready, 0);
      run_count(n);
      check("run_len", n, 19);
      check("rd_addr0", mem_addrB, 8);
      wait_out("out0", 36'hA5);
      repeat (10) step();
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 36'hA5);
      out_ready = 1'b1;
      step();
      check("bp_release", out_valid, 0);
      check("rd_addr1", mem_addrB, 9);
      wait_out("out1", 36'h5A);
      step();
      out_ready = 1'b0;
      check("f1_idle", busy, 0);

      // Frame 2: back-to-back tick, core write passthrough, ticks during RUN
      load2(36'h33, 36'h44);
      check("b2b_overrun", overrun_cnt, ovr(exp_ovr));
      core_we = 1'b1; core_addrW = 10'd9; core_dataW = 36'h123; core_addrB = 10'd3;
      sample_tick = 1'b1;
      #1;
      check("pt_we", mem_we, 1);
      check("pt_addrW", mem_addrW, 9);
      check("pt_dataW", mem_dataW, 36'h123);
      check("pt_addrB", mem_addrB, 3);
      repeat (3) step();
      sample_tick = 1'b0;
      core_we = 1'b0;
      run_count(n);
      check("run_len_rest", n, 16);
      core_we = 1'b1;
      #1;
      check("core_we_gated", mem_we, 0);
      core_we = 1'b0;
      exp_ovr += 3;
      check("ovr_run", overrun_cnt, ovr(exp_ovr));
      out_ready = 1'b1;
      wait_out("f2_out0", 36'hA5);
      step();
      wait_out("f2_out1", 36'h123);
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      exp_ovr += 1;
      check("ovr_final_hold", overrun_cnt, ovr(exp_ovr));
      check("f2_idle", busy, 0);
      out_ready = 1'b0;

      // Frame 3: reset at RUN cycle 5
      load2(36'h66, 36'h77);
      repeat (4) step();
      check("mid_run", core_start, 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp_ovr = 0;
      check("rr_core_start", core_start, 1);
      check("rr_out_valid", out_valid, 0);
      check("rr_busy", busy, 0);
      check("rr_in_ready", in_ready, 0);
      check("rr_overrun", overrun_cnt, 0);
      load2(36'h11, 36'h22);
      run_count(n);
      check("rr_run_len", n, 19);
      out_ready = 1'b1;
      wait_out("rr_out0", 36'hA5);
      step();
      wait_out("rr_out1", 36'h123);
      step();
      out_ready = 1'b0;
      check("rr_idle", busy, 0);

      // Saturation: hold the tick while stalled in LOAD
      sample_tick = 1'b1;
      step();
      check("sat_load", in_ready, 1);
      repeat (300) step();
      sample_tick = 1'b0;
      exp_ovr += 300;
      check("ovr_sat", overrun_cnt, ovr(exp_ovr));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
